// File: rtl/sram_arb_if.sv
// One requester port of the SRAM arbiter: request handshake plus fixed-latency response.
// The master drives the request and holds its payload stable while ready is low.
interface sram_arb_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [22:0] addr;
  logic [63:0] wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/sram_arb.sv
// Two-port round-robin arbiter onto a single synchronous SRAM, one request per cycle.
// Every accepted request answers exactly 2 cycles later; ready is held low during reset and zero-fill.
module sram_arb #(
  parameter int unsigned ROW_DEPTH = 4096,
  parameter bit          INIT_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  sram_arb_if.slave   p0,
  sram_arb_if.slave   p1,
  output logic        busy,
  output logic [22:0] sram_addr,
  output logic [63:0] sram_wdata,
  output logic        sram_we,
  input  logic [63:0] sram_rdata
);

  localparam int unsigned FILL_WORDS = 32 * ROW_DEPTH;
  localparam int unsigned CW         = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(FILL_WORDS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic vld;
    logic port;
    logic rd;
    logic err;
  } tag_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic [22:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  tag_t          t1_q, t1_d, t2_q;
  logic [1:0]    rsp_vld_q, rsp_vld_d;
  logic          rsp_err_q, rsp_err_d;
  logic [63:0]   rsp_rdata_q, rsp_rdata_d;

  logic        gnt0, gnt1, run, rdy0, rdy1, acc, row_ok;
  logic        sel_we;
  logic [22:0] sel_addr;
  logic [63:0] sel_wdata;

  // Pointer port wins only under contention; a lone requester is always granted.
  assign gnt0 = p0.valid && (!p1.valid || !ptr_q);
  assign gnt1 = p1.valid && (!p0.valid || ptr_q);
  assign run  = (state_q == ST_RUN) && !rst;
  assign rdy0 = run && gnt0;
  assign rdy1 = run && gnt1;
  assign acc  = rdy0 || rdy1;

  assign sel_we    = rdy1 ? p1.we    : p0.we;
  assign sel_addr  = rdy1 ? p1.addr  : p0.addr;
  assign sel_wdata = rdy1 ? p1.wdata : p0.wdata;
  assign row_ok    = 32'(sel_addr[22:5]) < ROW_DEPTH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    t1_d    = '0;
    case (state_q)
      ST_INIT: begin
        we_d    = 1'b1;
        addr_d  = 23'(cnt_q);
        wdata_d = '0;
        if (cnt_q == FILL_LAST) state_d = ST_RUN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (acc) begin
          ptr_d = rdy0;
          t1_d  = '{vld: 1'b1, port: rdy1, rd: !sel_we, err: !row_ok};
          // Out-of-range rows are answered with an error but never reach the SRAM.
          if (row_ok) begin
            we_d   = sel_we;
            addr_d = sel_addr;
            if (sel_we) wdata_d = sel_wdata;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rsp_vld_d   = {t2_q.vld && t2_q.port, t2_q.vld && !t2_q.port};
    rsp_err_d   = t2_q.vld && t2_q.err;
    rsp_rdata_d = (t2_q.vld && t2_q.rd && !t2_q.err) ? sram_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      t1_q        <= '0;
      t2_q        <= '0;
      rsp_vld_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      t1_q        <= t1_d;
      t2_q        <= t1_q;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign busy       = (state_q == ST_INIT);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we    = we_q;

  assign p0.ready     = rdy0;
  assign p1.ready     = rdy1;
  assign p0.rsp_valid = rsp_vld_q[0];
  assign p1.rsp_valid = rsp_vld_q[1];
  assign p0.rsp_err   = rsp_vld_q[0] && rsp_err_q;
  assign p1.rsp_err   = rsp_vld_q[1] && rsp_err_q;
  assign p0.rsp_rdata = rsp_vld_q[0] ? rsp_rdata_q : '0;
  assign p1.rsp_rdata = rsp_vld_q[1] ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: table of single requests plus arbitration, reset and zero-fill sequences,
// with a cycle-indexed response scoreboard and behavioural SRAMs.
module tb_sram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  sram_arb_if p0_if ();
  sram_arb_if p1_if ();
  sram_arb_if q0_if ();
  sram_arb_if q1_if ();

  logic        busy, sram_we;
  logic [22:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata = '0;
  logic        busy2, sram2_we;
  logic [22:0] sram2_addr;
  logic [63:0] sram2_wdata;
  logic [63:0] sram2_rdata = '0;

  sram_arb #(.ROW_DEPTH(4096), .INIT_ZERO(1'b0)) u_dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if), .busy(busy),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_rdata(sram_rdata)
  );

  sram_arb #(.ROW_DEPTH(4), .INIT_ZERO(1'b1)) u_init (
    .clk(clk), .rst(rst2), .p0(q0_if), .p1(q1_if), .busy(busy2),
    .sram_addr(sram2_addr), .sram_wdata(sram2_wdata), .sram_we(sram2_we), .sram_rdata(sram2_rdata)
  );

  function automatic logic [63:0] pat(input logic [22:0] a);
    return {32'hA5A5_5A5A, 9'h0, a};
  endfunction

  logic [63:0] mem  [int];
  logic [63:0] mem2 [int];

  // Read-first synchronous SRAMs; never-written words return an address-derived pattern.
  always @(posedge clk) begin
    sram_rdata <= mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : pat(sram_addr);
    if (sram_we) mem[int'(sram_addr)] = sram_wdata;
    sram2_rdata <= mem2.exists(int'(sram2_addr)) ? mem2[int'(sram2_addr)] : pat(sram2_addr);
    if (sram2_we) mem2[int'(sram2_addr)] = sram2_wdata;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    bit          port;
    bit          err;
    logic [63:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic push(input bit port, input bit err, input logic [63:0] rdata);
    exp_t e;
    e.due   = cyc + 3;
    e.port  = port;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  logic [65:0] exp0, exp1;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      exp0 = '0;
      exp1 = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        if (sb[0].port) exp1 = {1'b1, sb[0].err, sb[0].rdata};
        else            exp0 = {1'b1, sb[0].err, sb[0].rdata};
        void'(sb.pop_front());
      end
      chk("p0_rsp", 128'({p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata}), 128'(exp0));
      chk("p1_rsp", 128'({p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata}), 128'(exp1));
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [22:0] addr;
    logic [63:0] wdata;
    bit          exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  logic [22:0] last_addr  = '0;
  logic [63:0] last_wdata = '0;

  task automatic drive_port(input bit port, input bit vld, input bit we,
                            input logic [22:0] addr, input logic [63:0] wdata);
    if (port) begin
      p1_if.valid = vld; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end else begin
      p0_if.valid = vld; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end
  endtask

  // Called just after a clock edge; returns just after the accept edge.
  task automatic issue(input vec_t v);
    logic rdy;
    drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    drive_port(!v.port, 1'b0, 1'b0, '0, '0);
    #1;
    chk("ready", 128'({p0_if.ready, p1_if.ready}), 128'({!v.port, v.port}));
    rdy = v.port ? p1_if.ready : p0_if.ready;
    if (rdy) push(v.port, v.exp_err, v.exp_rdata);
    @(posedge clk); #1;
    p0_if.valid = 1'b0;
    p1_if.valid = 1'b0;
    if (!v.exp_err) begin
      last_addr = v.addr;
      if (v.we) last_wdata = v.wdata;
    end
    chk("sram_regs", 128'({sram_we, sram_addr, sram_wdata}),
        128'({v.we && !v.exp_err, last_addr, last_wdata}));
  endtask

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nb, nw, guard;
    bit got;

    tbl[0] = '{0, 1, 23'h000021, 64'hDEADBEEF_00000001, 0, 64'h0};
    tbl[1] = '{0, 0, 23'h000021, 64'h0, 0, 64'hDEADBEEF_00000001};
    tbl[2] = '{0, 1, 23'h000003, 64'h55, 0, 64'h0};
    tbl[3] = '{1, 0, 23'h000003, 64'h0, 0, 64'h55};
    tbl[4] = '{1, 0, 23'h020000, 64'h0, 1, 64'h0};
    tbl[5] = '{1, 1, 23'h020000, 64'h1111_2222_3333_4444, 1, 64'h0};
    tbl[6] = '{0, 0, 23'h7FFFFF, 64'h0, 1, 64'h0};
    tbl[7] = '{1, 1, 23'h01FFFF, 64'h1234, 0, 64'h0};
    tbl[8] = '{0, 0, 23'h01FFFF, 64'h0, 0, 64'h1234};
    tbl[9] = '{1, 0, 23'h000100, 64'h0, 0, pat(23'h000100)};

    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    q0_if.valid = 0; q0_if.we = 0; q0_if.addr = '0; q0_if.wdata = '0;
    q1_if.valid = 0; q1_if.we = 0; q1_if.addr = '0; q1_if.wdata = '0;

    // Reset state of both instances, and ready suppression while reset is high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sram", 128'({sram_we, sram_addr, sram_wdata}), 128'(0));
    chk("rst_rsp", 128'({p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata,
                         p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata}), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_busy_init", 128'({busy2, sram2_we}), 128'(2'b10));
    p0_if.valid = 1; p1_if.valid = 1;
    #1;
    chk("rst_ready", 128'({p0_if.ready, p1_if.ready}), 128'(0));
    p0_if.valid = 0; p1_if.valid = 0;
    @(posedge clk); #1;
    rst = 0;
    mon_en = 1;

    foreach (tbl[i]) issue(tbl[i]);

    // Both ports contend for 4 cycles: grants alternate starting at p0.
    drive_port(0, 1, 0, 23'h000021, '0);
    drive_port(1, 1, 0, 23'h000003, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", 128'({p0_if.ready, p1_if.ready}), 128'((i % 2 == 0) ? 2'b10 : 2'b01));
      if (p0_if.ready) push(0, 0, 64'hDEADBEEF_00000001);
      if (p1_if.ready) push(1, 0, 64'h55);
      @(posedge clk); #1;
    end
    p0_if.valid = 0; p1_if.valid = 0;
    repeat (4) @(posedge clk);
    #1;

    // Reset the cycle after an accepted read: its response must never appear.
    drive_port(0, 1, 0, 23'h000021, '0);
    #1;
    chk("prerst_ready", 128'(p0_if.ready), 128'(1));
    @(posedge clk); #1;
    rst = 1;
    p0_if.valid = 1; p1_if.valid = 1;
    drive_port(1, 1, 0, 23'h000003, '0);
    #1;
    chk("rst_mid_ready", 128'({p0_if.ready, p1_if.ready}), 128'(0));
    @(posedge clk); #1;
    chk("rst_mid_sram", 128'({sram_we, sram_addr, sram_wdata}), 128'(0));
    chk("rst_mid_rsp", 128'({p0_if.rsp_valid, p1_if.rsp_valid}), 128'(0));
    rst = 0;
    last_addr = '0; last_wdata = '0;
    #1;
    chk("rst_ptr", 128'({p0_if.ready, p1_if.ready}), 128'(2'b10));
    if (p0_if.ready) push(0, 0, 64'hDEADBEEF_00000001);
    @(posedge clk); #1;
    p0_if.valid = 0; p1_if.valid = 0;
    repeat (5) @(posedge clk);
    #1;

    // Zero-fill: interrupt it, then watch one complete fill of 4 rows x 32 banks.
    rst2 = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("init_we_mid", 128'({busy2, sram2_we}), 128'(2'b11));
    rst2 = 1;
    @(posedge clk); #1;
    chk("init_restart", 128'({busy2, sram2_we, sram2_addr}), 128'({2'b10, 23'h0}));
    rst2 = 0;
    q0_if.valid = 1; q0_if.we = 0; q0_if.addr = 23'h00007F;
    nb = 0; nw = 0; guard = 0;
    while (busy2 && guard < 400) begin
      nb++; guard++;
      #1;
      chk("init_ready", 128'(q0_if.ready), 128'(0));
      @(posedge clk); #1;
      if (sram2_we) begin
        chk("init_write", 128'({sram2_addr, sram2_wdata}), 128'({23'(nw), 64'h0}));
        nw++;
      end
    end
    chk("init_busy_cycles", 128'(nb), 128'(128));
    chk("init_write_count", 128'(nw), 128'(128));
    #1;
    chk("init_ready_run", 128'(q0_if.ready), 128'(1));
    @(posedge clk); #1;
    q0_if.valid = 0;
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      if (q0_if.rsp_valid) begin
        got = 1;
        chk("init_rd", 128'({q0_if.rsp_err, q0_if.rsp_rdata}), 128'(0));
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("init_rsp_seen", 128'(got), 128'(1));

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter ROW_DEPTH, default 4096: number of valid rows per bank; a row index is valid when addr[22:5] < ROW_DEPTH.
REQ-002 Parameter INIT_ZERO, default 0: when 1, zero-fill the whole SRAM after every reset.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pN_valid  in  1  request valid from port N, for N = 0, 1.
REQ-006 pN_ready  out  1  request accepted this cycle, for N = 0, 1.
REQ-007 pN_we  in  1  1 = write, 0 = read.
REQ-008 pN_addr  in  23  addr[4:0] = bank, addr[22:5] = row.
REQ-009 pN_wdata  in  64  write data.
REQ-010 pN_rsp_valid  out  1  one-cycle response pulse.
REQ-011 pN_rsp_err  out  1  response carries an address error; qualified by pN_rsp_valid.
REQ-012 pN_rsp_rdata  out  64  read data; 0 for writes and errors.
REQ-013 busy  out  1  zero-fill in progress.
REQ-014 sram_addr  out  23  to SRAM address; registered.
REQ-015 sram_wdata  out  64  to SRAM data_in; registered.
REQ-016 sram_we  out  1  to SRAM write_en; registered.
REQ-017 sram_rdata  in  64  from SRAM data_out; valid one cycle after the SRAM samples an address.

Function
REQ-018 Handshake: a request transfers on a cycle where pN_valid && pN_ready. pN_ready is combinational from the valid inputs and arbiter state. pN_ready is never high without pN_valid. At most one port is ready per cycle.
REQ-019 Arbitration is round-robin with a 1-bit priority pointer.
- Only one port valid: that port is granted.
- Both ports valid: the pointer port is granted.
- After any grant, the pointer moves to the non-granted port.
- No grant: the pointer holds.
REQ-020 Throughput: one request per cycle total. A held request (valid, not ready) shall keep its payload stable; the block does not check this.
REQ-021 Accepted request with valid row: on the accept edge, register sram_addr = pN_addr and sram_we = pN_we; register sram_wdata = pN_wdata for writes.
REQ-022 Accepted request with invalid row (addr[22:5] >= ROW_DEPTH): sram_we = 0 and sram_addr holds its previous value; the request is still answered.
REQ-023 Cycles with no accepted request: sram_we = 0; sram_addr and sram_wdata hold.
REQ-024 Latency: fixed at 2 cycles for every accepted request. For a request accepted at edge E0, pN_rsp_valid is high for exactly the cycle after edge E2 = E0 + 2, on the accepting port only.
REQ-025 Response content:
- Read: rsp_rdata = sram_rdata sampled at edge E2; rsp_err = 0.
- Write: rsp_rdata = 0; rsp_err = 0.
- Error: rsp_rdata = 0; rsp_err = 1.
REQ-026 A 2-deep tag pipeline carries port, read/write and error information for each issued request. Back-to-back requests from alternating ports produce back-to-back responses in acceptance order.
REQ-027 A read issued on the cycle after a write to the same address returns the new data. A read and write to one address on the same edge cannot occur, since only one request is issued per cycle.
REQ-028 Outside a response cycle, pN_rsp_valid = 0, pN_rsp_err = 0 and pN_rsp_rdata = 0.
REQ-029 State machine states: INIT and RUN.
- INIT_ZERO = 1: reset enters INIT.
- INIT_ZERO = 0: reset enters RUN.
REQ-030 INIT behaviour:
- busy = 1 and pN_ready = 0.
- A linear counter c runs 0 .. 32*ROW_DEPTH-1, one write per cycle.
- Each cycle: sram_addr = {c[row bits], c[4:0]}, sram_wdata = 0, sram_we = 1.
REQ-031 INIT to RUN: on the edge that issues the final write (c = 32*ROW_DEPTH-1), the state moves to RUN and busy falls. Requests may be accepted from the following cycle.
REQ-032 Zero-fill writes produce no responses.

Reset
REQ-033 On rst = 1 at a clock edge, the following outputs and registers reset:
- sram_we = 0, sram_addr = 0, sram_wdata = 0.
- All pN_rsp_* = 0.
- Priority pointer = port 0; INIT counter = 0.
- busy = INIT_ZERO.
REQ-034 pN_ready = 0 while rst is high.
REQ-035 Reset mid-operation discards all in-flight responses; no response pulses appear after reset for pre-reset requests.
REQ-036 Reset during INIT restarts the fill from c = 0.

Verification
REQ-037 p0 write addr 0x000021 (bank 1, row 1) data 0xDEADBEEF_00000001, then p0 read the same address -> write response at +2 with err = 0 and rdata = 0; read response at +2 with rdata = 0xDEADBEEF_00000001.
REQ-038 p0 and p1 hold valid reads for 4 cycles -> grants alternate p0, p1, p0, p1; 4 responses return in that order, each 2 cycles after its grant.
REQ-039 p1 read addr with row = 4096 (addr = 0x020000) -> sram_we stays 0, sram_addr unchanged; p1_rsp_valid = 1 with err = 1 and rdata = 0 after 2 cycles.
REQ-040 Assert rst in the cycle after p0 accepts a read -> no p0_rsp_valid pulse occurs; all outputs are at reset values after the reset edge.
REQ-041 INIT_ZERO = 1, ROW_DEPTH = 4 -> busy high for 128 cycles with 128 writes of 0 to sram_addr {row 0..3, bank 0..31}; p0_ready stays 0 until busy falls; then a p0 read of 0x00007F returns 0.
REQ-042 p0 write 0x55 to addr 0x000003, then on the next cycle p1 read 0x000003 -> p1 response rdata = 0x55.
